// File: rtl/cmp_window_stats_pkg.sv
// Shared definitions for the comparison-statistics block: comparator result
// codes, the two-state window FSM encoding and a code-validity helper.
package cmp_window_stats_pkg;

    // One-hot comparator result codes, op[3:1]
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    // Counter slots: three per-code counters plus the total sample counter
    localparam int NUM_CNT = 4;
    localparam int CNT_GT  = 0;
    localparam int CNT_EQ  = 1;
    localparam int CNT_LT  = 2;
    localparam int CNT_ALL = 3;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_e;

    // True only for the three legal one-hot codes
    function automatic logic op_is_valid(input logic [2:0] op_code);
        return (op_code == CMP_GT) || (op_code == CMP_EQ) || (op_code == CMP_LT);
    endfunction

endpackage

// File: rtl/cmp_cnt_reg.sv
// Counter with increment and synchronous clear; clear has priority so a
// window can close on the same cycle its last sample is counted.
module cmp_cnt_reg #(
    parameter int cntWidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_i,
    input  logic                clr_i,
    output logic [cntWidth-1:0] cnt_o
);

    logic [cntWidth-1:0] cnt_q;
    logic [cntWidth-1:0] cnt_d;

    // Next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + cntWidth'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cmp_window_stats.sv
// Windowed statistics over comparator results: counts GT/EQ/LT codes and
// samples, optionally tracks the largest winner and smallest loser, and
// presents one held report per window on a valid/ready handshake.
// Optional feature macro: CMP_WINDOW_MINMAX_EN enables extreme tracking;
// without it out_max/out_min are constant zero.
module cmp_window_stats
    import cmp_window_stats_pkg::*;
#(
    parameter int busWidth = 4,
    parameter int winLen   = 16,
    parameter int cntWidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [busWidth-1:0] a,
    input  logic [busWidth-1:0] b,
    input  logic [3:1]          op,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [cntWidth-1:0] out_gt,
    output logic [cntWidth-1:0] out_eq,
    output logic [cntWidth-1:0] out_lt,
    output logic [cntWidth-1:0] out_cnt,
    output logic [busWidth-1:0] out_max,
    output logic [busWidth-1:0] out_min,
    output logic                err
);

    state_e              state_q, state_d;
    logic                accept;
    logic                code_ok;
    logic                sample;
    logic                close;
    logic [NUM_CNT-1:0]  inc_vec;
    logic [cntWidth-1:0] cnt_val [NUM_CNT];
    logic [cntWidth-1:0] cnt_res [NUM_CNT];
    logic [cntWidth-1:0] out_gt_q, out_eq_q, out_lt_q, out_cnt_q;
    logic                err_q;

    // Samples are only taken while no report is pending
    assign accept  = in_valid && (state_q == ST_ACCUM);
    assign code_ok = op_is_valid(op);
    assign sample  = accept && code_ok;

    assign inc_vec[CNT_GT]  = sample && (op == CMP_GT);
    assign inc_vec[CNT_EQ]  = sample && (op == CMP_EQ);
    assign inc_vec[CNT_LT]  = sample && (op == CMP_LT);
    assign inc_vec[CNT_ALL] = sample;

    // Window closes on reaching winLen, or on flush with something to report;
    // the count tested already includes this cycle's sample.
    assign close = (state_q == ST_ACCUM) &&
                   ((sample && (cnt_res[CNT_ALL] == cntWidth'(winLen))) ||
                    (flush && (cnt_res[CNT_ALL] != '0)));

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            cmp_cnt_reg #(
                .cntWidth(cntWidth)
            ) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc_i(inc_vec[gi]),
                .clr_i(close),
                .cnt_o(cnt_val[gi])
            );
            // Value the counter would hold after this cycle, used for the report
            assign cnt_res[gi] = cnt_val[gi] + cntWidth'(inc_vec[gi]);
        end
    endgenerate

    // Next-state: ACCUM -> REPORT on window close, REPORT -> ACCUM on handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM:  if (close)     state_d = ST_REPORT;
            ST_REPORT: if (out_ready) state_d = ST_ACCUM;
            default:                  state_d = ST_ACCUM;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    assign out_valid = (state_q == ST_REPORT);
    assign in_ready  = (state_q == ST_ACCUM);

    // Report count fields capture the closing totals and hold until replaced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_gt_q  <= '0;
            out_eq_q  <= '0;
            out_lt_q  <= '0;
            out_cnt_q <= '0;
        end else if (close) begin
            out_gt_q  <= cnt_res[CNT_GT];
            out_eq_q  <= cnt_res[CNT_EQ];
            out_lt_q  <= cnt_res[CNT_LT];
            out_cnt_q <= cnt_res[CNT_ALL];
        end
    end

    // Sticky error for any accepted non-one-hot code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && !code_ok) begin
            err_q <= 1'b1;
        end
    end

    assign out_gt  = out_gt_q;
    assign out_eq  = out_eq_q;
    assign out_lt  = out_lt_q;
    assign out_cnt = out_cnt_q;
    assign err     = err_q;

`ifdef CMP_WINDOW_MINMAX_EN
    logic [busWidth-1:0] winner, loser;
    logic [busWidth-1:0] max_q, max_d, min_q, min_d;
    logic [busWidth-1:0] max_res, min_res;
    logic [busWidth-1:0] out_max_q, out_min_q;

    // Winner/loser selection and running extremes including this sample
    always_comb begin
        winner  = (op == CMP_LT) ? b : a;
        loser   = (op == CMP_LT) ? a : b;
        max_res = (sample && (winner > max_q)) ? winner : max_q;
        min_res = (sample && (loser < min_q)) ? loser : min_q;
        max_d   = close ? '0 : max_res;
        min_d   = close ? '1 : min_res;
    end

    // Extreme trackers: min starts at all-ones so the first loser always wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q     <= '0;
            min_q     <= '1;
            out_max_q <= '0;
            out_min_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
            if (close) begin
                out_max_q <= max_res;
                out_min_q <= min_res;
            end
        end
    end

    assign out_max = out_max_q;
    assign out_min = out_min_q;
`else
    // Operands only feed the extreme trackers, which are absent in this build
    logic unused_operands;
    assign unused_operands = ^{a, b};
    assign out_max = '0;
    assign out_min = '0;
`endif

endmodule

// File: tb/tb_cmp_window_stats.sv
// Bench for cmp_window_stats (busWidth=4, winLen=4): a directed vector table,
// a reset-mid-window sequence, then randomized traffic against a queue model.
module tb_cmp_window_stats;

    localparam int BW = 4;
    localparam int WL = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [3:1]    op;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_gt, out_eq, out_lt, out_cnt;
    logic [BW-1:0] out_max, out_min;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;

    cmp_window_stats #(
        .busWidth(BW),
        .winLen  (WL),
        .cntWidth(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_gt   (out_gt),
        .out_eq   (out_eq),
        .out_lt   (out_lt),
        .out_cnt  (out_cnt),
        .out_max  (out_max),
        .out_min  (out_min),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       fl;
        logic       ordy;
        logic       eov;
        int         egt, eeq, elt, ecnt, emax, emin;
        logic       eerr;
    } vec_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } smp_t;

    vec_t tbl[27];
    smp_t win_q[$];
    logic m_ov, m_err;
    int   m_gt, m_eq, m_lt, m_cnt, m_max, m_min;

    // Extremes are expected only when tracking is compiled in
    function automatic int mm(input int v);
`ifdef CMP_WINDOW_MINMAX_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic vec_t mk(input logic iv, input int av, input int bv, input logic [2:0] opv,
                                input logic fl, input logic ordy, input logic eov,
                                input int egt, input int eeq, input int elt, input int ecnt,
                                input int emax, input int emin, input logic eerr);
        vec_t v;
        v.iv = iv; v.a = 4'(av); v.b = 4'(bv); v.op = opv; v.fl = fl; v.ordy = ordy;
        v.eov = eov; v.egt = egt; v.eeq = eeq; v.elt = elt; v.ecnt = ecnt;
        v.emax = mm(emax); v.emin = mm(emin); v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] av, input logic [3:0] bv,
                         input logic [2:0] opv, input logic fl, input logic ordy);
        in_valid  = iv;
        a         = av;
        b         = bv;
        op        = opv;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Apply inputs at the falling edge, let one rising edge pass, sample at the next falling edge
    task automatic step(input logic iv, input logic [3:0] av, input logic [3:0] bv,
                        input logic [2:0] opv, input logic fl, input logic ordy);
        drive(iv, av, bv, opv, fl, ordy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic eov, input int egt, input int eeq,
                             input int elt, input int ecnt, input int emax, input int emin,
                             input logic eerr);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(eov));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(!eov));
        chk({tag, " err"}, 32'(err), 32'(eerr));
        if (eov) begin
            chk({tag, " out_gt"}, 32'(out_gt), egt);
            chk({tag, " out_eq"}, 32'(out_eq), eeq);
            chk({tag, " out_lt"}, 32'(out_lt), elt);
            chk({tag, " out_cnt"}, 32'(out_cnt), ecnt);
            chk({tag, " out_max"}, 32'(out_max), emax);
            chk({tag, " out_min"}, 32'(out_min), emin);
        end
        $display("%s: ov=%0b gt=%0d eq=%0d lt=%0d cnt=%0d max=%0d min=%0d err=%0b",
                 tag, out_valid, out_gt, out_eq, out_lt, out_cnt, out_max, out_min, err);
    endtask

    // Reference model: window as a list of accepted samples, statistics
    // recomputed from the list whenever the window closes.
    task automatic model_step(input logic iv, input logic [3:0] av, input logic [3:0] bv,
                              input logic [2:0] opv, input logic fl, input logic ordy);
        smp_t s;
        int   w, l;
        if (m_ov) begin
            if (ordy) m_ov = 1'b0;
        end else begin
            if (iv) begin
                if (opv == 3'b100 || opv == 3'b010 || opv == 3'b001) begin
                    s.a = av; s.b = bv; s.op = opv;
                    win_q.push_back(s);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (win_q.size() == WL || (fl && win_q.size() > 0)) begin
                m_gt = 0; m_eq = 0; m_lt = 0; m_max = 0; m_min = 15;
                foreach (win_q[i]) begin
                    if (win_q[i].op == 3'b100) m_gt++;
                    if (win_q[i].op == 3'b010) m_eq++;
                    if (win_q[i].op == 3'b001) m_lt++;
                    w = (win_q[i].op == 3'b001) ? int'(win_q[i].b) : int'(win_q[i].a);
                    l = (win_q[i].op == 3'b001) ? int'(win_q[i].a) : int'(win_q[i].b);
                    if (w > m_max) m_max = w;
                    if (l < m_min) m_min = l;
                end
                m_cnt = win_q.size();
                win_q.delete();
                m_ov = 1'b1;
            end
        end
    endtask

    initial begin
        logic       iv, fl, ordy;
        logic [3:0] av, bv;
        logic [2:0] opv;

        // iv a b op fl ordy | eov gt eq lt cnt max min err
        tbl[0]  = mk(1, 1, 8, 3'b001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8, 1, 3'b100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 5, 5, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 3, 2, 3'b100, 0, 1, 1, 2, 1, 1, 4, 8, 1, 0);
        tbl[4]  = mk(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 2, 3, 3'b001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 7, 7, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 3'b000, 1, 1, 1, 0, 1, 1, 2, 7, 2, 0);
        tbl[8]  = mk(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 9, 1, 3'b110, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[12] = mk(1, 4, 4, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk(1, 0, 15, 3'b001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[14] = mk(1, 15, 0, 3'b100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[15] = mk(1, 6, 9, 3'b001, 0, 0, 1, 1, 1, 2, 4, 15, 0, 1);
        tbl[16] = mk(1, 1, 2, 3'b001, 0, 0, 1, 1, 1, 2, 4, 15, 0, 1);
        tbl[17] = mk(1, 2, 1, 3'b100, 1, 0, 1, 1, 1, 2, 4, 15, 0, 1);
        tbl[18] = mk(1, 3, 3, 3'b010, 0, 0, 1, 1, 1, 2, 4, 15, 0, 1);
        tbl[19] = mk(0, 0, 0, 3'b000, 1, 0, 1, 1, 1, 2, 4, 15, 0, 1);
        tbl[20] = mk(1, 4, 5, 3'b001, 0, 0, 1, 1, 1, 2, 4, 15, 0, 1);
        tbl[21] = mk(1, 7, 7, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[22] = mk(1, 1, 2, 3'b001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[23] = mk(1, 3, 3, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[24] = mk(1, 2, 1, 3'b100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[25] = mk(1, 9, 3, 3'b100, 0, 1, 1, 2, 1, 1, 4, 9, 1, 1);
        tbl[26] = mk(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        rst = 1'b1;
        drive(0, 0, 0, 3'b000, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset out_gt", 32'(out_gt), 0);
        chk("reset out_cnt", 32'(out_cnt), 0);
        chk("reset out_max", 32'(out_max), 0);
        chk("reset out_min", 32'(out_min), 0);
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 27; i++) begin
            step(tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].fl, tbl[i].ordy);
            check_out($sformatf("tbl[%0d]", i), tbl[i].eov, tbl[i].egt, tbl[i].eeq,
                      tbl[i].elt, tbl[i].ecnt, tbl[i].emax, tbl[i].emin, tbl[i].eerr);
        end

        // Reset two samples into a window: everything clears immediately
        step(1, 4'd2, 4'd5, 3'b001, 0, 1);
        step(1, 4'd6, 4'd1, 3'b100, 0, 1);
        rst = 1'b1;
        #1;
        check_out("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("midrst out_gt", 32'(out_gt), 0);
        chk("midrst out_cnt", 32'(out_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 4'd3, 4'd3, 3'b010, 0, 1);
        step(1, 4'd1, 4'd4, 3'b001, 0, 1);
        step(1, 4'd5, 4'd2, 3'b100, 0, 1);
        check_out("postrst-3", 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 4'd7, 4'd6, 3'b100, 0, 1);
        check_out("postrst-4", 1, 2, 1, 1, 4, mm(7), mm(1), 0);
        step(0, 4'd0, 4'd0, 3'b000, 0, 1);
        check_out("postrst-ack", 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the model
        win_q.delete();
        m_ov = 1'b0; m_err = 1'b0;
        m_gt = 0; m_eq = 0; m_lt = 0; m_cnt = 0; m_max = 0; m_min = 15;
        for (int c = 0; c < 600; c++) begin
            iv   = ($urandom_range(0, 9) < 7);
            av   = 4'($urandom_range(0, 15));
            bv   = 4'($urandom_range(0, 15));
            opv  = (c > 300 && $urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7))
                                                           : 3'(3'b001 << $urandom_range(0, 2));
            fl   = ($urandom_range(0, 9) == 0);
            ordy = ($urandom_range(0, 9) < 6);
            model_step(iv, av, bv, opv, fl, ordy);
            step(iv, av, bv, opv, fl, ordy);
            check_out($sformatf("rnd[%0d]", c), m_ov, m_gt, m_eq, m_lt, m_cnt,
                      mm(m_max), mm(m_min), m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
